keypad_emulator: RTL

- Synthesizable model of a 4x4 keypad matrix: the contact side of the row-scan/column-sense interface used by the keypad scanner.
- Watches the scanner's active-low row drive (row_n) and returns the active-low column sense (col_n) for one commanded key press.
- The press includes programmable contact bounce on make and on break, a hold time and a release gap.
- Placed between a sequence source (switches or a test controller) and the scanner, for on-board loopback testing of scanner and debounce without a physical keypad.

---
 rtl/keypad_emulator.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// Contact-side model of a 4x4 keypad matrix: answers the scanner's active-low row
// drive with active-low column sense for one commanded press with bounce, hold and gap.
module keypad_emulator #(
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned HOLD_CYCLES    = 24'd4000000,
  parameter int unsigned BOUNCE_TOGGLES = 6,
  parameter int unsigned BOUNCE_PERIOD  = 24'd20000,
  parameter int unsigned GAP_CYCLES     = 24'd2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  input  logic [3:0] key_in,
  input  logic       press_req,
  output logic [3:0] col_n,
  output logic       busy,
  output logic       done,
  output logic [3:0] key_active
);

  // A phase length of 0 behaves as 1, so each terminal count is max(len,1)-1.
  localparam logic [CNT_WIDTH-1:0] HOLD_T   = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] PER_T    = CNT_WIDTH'(BOUNCE_PERIOD);
  localparam logic [CNT_WIDTH-1:0] GAP_T    = CNT_WIDTH'(GAP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = (HOLD_T == '0) ? '0 : HOLD_T - CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PER_LAST  = (PER_T == '0) ? '0 : PER_T - CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = (GAP_T == '0) ? '0 : GAP_T - CNT_WIDTH'(1);

  localparam int unsigned TOG_W = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;
  localparam logic [TOG_W-1:0] TOG_LAST =
    TOG_W'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);
  localparam bit BOUNCE_EN = (BOUNCE_TOGGLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  state_t               r_state, w_state;
  logic [CNT_WIDTH-1:0] r_timer, w_timer;
  logic [TOG_W-1:0]     r_tog, w_tog;
  logic                 r_contact, w_contact;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic [3:0]           r_key, w_key;
  logic [3:0]           r_col, w_col;
  logic                 w_tick;

  assign w_tick = (r_timer == PER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_tog     <= '0;
      r_contact <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_key     <= 4'h0;
      r_col     <= 4'b1111;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_tog     <= w_tog;
      r_contact <= w_contact;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_key     <= w_key;
      r_col     <= w_col;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer + CNT_WIDTH'(1);
    w_tog     = r_tog;
    w_contact = r_contact;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_key     = r_key;
    case (r_state)
      S_IDLE: begin
        // busy is still high during the done cycle and falls on the next edge
        w_timer   = '0;
        w_tog     = '0;
        w_contact = 1'b0;
        w_busy    = 1'b0;
        if (press_req) begin
          w_key     = key_in;
          w_busy    = 1'b1;
          w_contact = 1'b1;
          w_state   = BOUNCE_EN ? S_BOUNCE_IN : S_HOLD;
        end
      end
      S_BOUNCE_IN: begin
        if (w_tick) begin
          w_timer = '0;
          if (r_tog == TOG_LAST) begin
            w_tog     = '0;
            w_contact = 1'b1;
            w_state   = S_HOLD;
          end else begin
            w_tog     = r_tog + TOG_W'(1);
            w_contact = ~r_contact;
          end
        end
      end
      S_HOLD: begin
        w_contact = 1'b1;
        if (r_timer == HOLD_LAST) begin
          w_timer   = '0;
          w_contact = 1'b0;
          w_state   = BOUNCE_EN ? S_BOUNCE_OUT : S_GAP;
        end
      end
      S_BOUNCE_OUT: begin
        if (w_tick) begin
          w_timer = '0;
          if (r_tog == TOG_LAST) begin
            w_tog     = '0;
            w_contact = 1'b0;
            w_state   = S_GAP;
          end else begin
            w_tog     = r_tog + TOG_W'(1);
            w_contact = ~r_contact;
          end
        end
      end
      S_GAP: begin
        w_contact = 1'b0;
        if (r_timer == GAP_LAST) begin
          w_timer = '0;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Column sense answers only when the key's own row is among the driven rows.
  always_comb begin
    w_col = 4'b1111;
    if (r_contact && !row_n[r_key[3:2]]) w_col[r_key[1:0]] = 1'b0;
  end

  assign col_n      = r_col;
  assign busy       = r_busy;
  assign done       = r_done;
  assign key_active = r_key;

endmodule
